// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
// Loads a program into instruction memory from an asynchronous byte-wide pin
// interface while holding the processor, then releases it with a restart
// pulse once DEPTH bytes have been written.
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require one extra
// checksum byte after the program; the 8-bit sum of all bytes must be zero
// for the load to be accepted.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   load_req   in   async level, high requests a load session
//   strobe_in  in   async byte strobe, rising edge marks data_in valid
//   data_in    in   program byte
//   wr_en      out  one-cycle instruction-memory write pulse
//   wr_addr    out  instruction-memory write address
//   wr_data    out  instruction-memory write data
//   cpu_hold   out  freezes the processor
//   cpu_rst    out  one-cycle processor restart pulse
//   load_done  out  a completed program is resident
//   load_err   out  last session aborted or failed its checksum
//   byte_cnt   out  bytes accepted in the current session
// ----------------------------------------------------------------------------
module prog_loader #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic       strobe_in,
    input  logic [7:0] data_in,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cpu_hold,
    output logic       cpu_rst,
    output logic       load_done,
    output logic       load_err,
    output logic [4:0] byte_cnt
);

    // Two flops is the floor for metastability protection.
    localparam int         NS       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK  = 3'd2,
`endif
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    logic [NS-1:0] strobe_sync_q;
    logic [NS-1:0] req_sync_q;
    logic          strobe_dly_q;
    logic          strobe_evt_s;
    logic          req_s;

    state_e     state_q,     state_d;
    logic [4:0] byte_cnt_q,  byte_cnt_d;
    logic       wr_en_q,     wr_en_d;
    logic [3:0] wr_addr_q,   wr_addr_d;
    logic [7:0] wr_data_q,   wr_data_d;
    logic       cpu_hold_q,  cpu_hold_d;
    logic       cpu_rst_q,   cpu_rst_d;
    logic       load_done_q, load_done_d;
    logic       load_err_q,  load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q,       sum_d;
`endif

    assign strobe_evt_s = strobe_sync_q[NS-1] & ~strobe_dly_q;
    assign req_s        = req_sync_q[NS-1];

    // Synchronizer chains for the pin inputs plus the strobe edge-detect delay
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_sync_q <= {NS{1'b0}};
            req_sync_q    <= {NS{1'b0}};
            strobe_dly_q  <= 1'b0;
        end else begin
            strobe_sync_q <= {strobe_sync_q[NS-2:0], strobe_in};
            req_sync_q    <= {req_sync_q[NS-2:0], load_req};
            strobe_dly_q  <= strobe_sync_q[NS-1];
        end
    end

    // Next-state, write-port and status decode
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 5'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // Abort has priority: a strobe in the same cycle is dropped.
                if (!req_s) begin
                    state_d = S_ERR;
                end else if (strobe_evt_s) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = byte_cnt_q[3:0];
                    wr_data_d  = data_in;
                    byte_cnt_d = byte_cnt_q + 5'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + data_in;
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_LOAD;
                    end
`else
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                // Checksum byte is counted but never written to memory.
                if (!req_s) begin
                    state_d = S_ERR;
                end else if (strobe_evt_s) begin
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    if ((sum_q + data_in) == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
`endif
            S_DONE: begin
                if (!req_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ERR: begin
                if (req_s) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 5'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end else begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they register
        // alongside the state they describe.
        cpu_hold_d  = (state_d == S_LOAD) || (state_d == S_ERR)
`ifdef PROG_LOADER_CHECKSUM_EN
                      || (state_d == S_CHK)
`endif
                      ;
        load_done_d = (state_d == S_DONE);
        load_err_d  = (state_d == S_ERR);
        cpu_rst_d   = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // State and registered output update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 5'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 4'd0;
            wr_data_q   <= 8'd0;
            cpu_hold_q  <= 1'b0;
            cpu_rst_q   <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_hold_q  <= cpu_hold_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign cpu_rst   = cpu_rst_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign byte_cnt  = byte_cnt_q;

endmodule
